// File: rtl/generic_slave_spi.sv
`default_nettype none
// ============================================================================
// Module   : generic_slave_spi
// Brief    : SPI slave running in the system clock domain. SCLK/SS/MOSI are
//            oversampled through 2-FF synchronizers; full-duplex words in all
//            four CPOL/CPHA modes, selectable bit order, valid/ready transmit
//            shadow register and single-cycle receive strobe.
// Revision : 1.0 - initial release
// ============================================================================
module generic_slave_spi #(
    parameter int unsigned        WordLen  = 8,
    parameter logic [WordLen-1:0] IdleWord = '0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               CPOL,
    input  logic               CPHA,
    input  logic               BitOrder,
    input  logic               SCLK,
    input  logic               SS,
    input  logic               MOSI,
    output logic               MISO,
    output logic               MISOEn,
    input  logic [WordLen-1:0] TxData,
    input  logic               TxValid,
    output logic               TxReady,
    output logic [WordLen-1:0] RxData,
    output logic               RxValid,
    output logic               TxUnderrun,
    output logic               Busy
);

    localparam int unsigned      CNT_W    = $clog2(WordLen);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WordLen - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_ACTIVE = 2'd2
    } state_e;

    logic               sclk_meta_q, sclk_sync_q, sclk_dly_q;
    logic               ss_meta_q, ss_sync_q;
    logic               mosi_meta_q, mosi_sync_q;
    logic               cpol_q, cpha_q, lsb_first_q;
    logic [WordLen-1:0] shadow_q;
    logic               shadow_full_q;
    state_e             state_q;
    logic [CNT_W-1:0]   bit_cnt_q;
    logic               fresh_q;
    logic [WordLen-1:0] tx_shift_q, rx_shift_q;
    logic               miso_q, miso_en_q, underrun_q;
    logic               rx_done_q, rx_valid_q;
    logic [WordLen-1:0] rx_data_q;

    logic               sclk_edge, lead_edge, trail_edge, sample_edge, shift_edge;
    logic               reload, word_start, last_sample, tx_hs;
    logic [WordLen-1:0] load_word_d, tx_shift_d, rx_shift_d;

    // SCLK edge classification relative to the frozen idle level
    assign sclk_edge   = sclk_sync_q ^ sclk_dly_q;
    assign lead_edge   = sclk_edge & (sclk_dly_q == cpol_q);
    assign trail_edge  = sclk_edge & (sclk_sync_q == cpol_q);
    assign sample_edge = cpha_q ? trail_edge : lead_edge;
    assign shift_edge  = cpha_q ? lead_edge : trail_edge;

    // A shift edge at a word boundary that is not the already-presented first
    // bit starts the next back-to-back word.
    assign reload      = (state_q == ST_ACTIVE) & ~ss_sync_q & shift_edge &
                         (bit_cnt_q == '0) & ~fresh_q;
    assign word_start  = ((state_q == ST_LOAD) & ~ss_sync_q) | reload;
    assign last_sample = (state_q == ST_ACTIVE) & sample_edge & (bit_cnt_q == LAST_BIT);
    assign tx_hs       = TxValid & ~shadow_full_q;

    assign load_word_d = shadow_full_q ? shadow_q : IdleWord;
    assign tx_shift_d  = lsb_first_q ? (tx_shift_q >> 1) : (tx_shift_q << 1);
    assign rx_shift_d  = lsb_first_q ? {mosi_sync_q, rx_shift_q[WordLen-1:1]}
                                     : {rx_shift_q[WordLen-2:0], mosi_sync_q};

    // Input synchronizers; SS resets to the deasserted level so Busy reads 0
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sclk_meta_q <= 1'b0;
            sclk_sync_q <= 1'b0;
            sclk_dly_q  <= 1'b0;
            ss_meta_q   <= 1'b1;
            ss_sync_q   <= 1'b1;
            mosi_meta_q <= 1'b0;
            mosi_sync_q <= 1'b0;
        end else begin
            sclk_meta_q <= SCLK;
            sclk_sync_q <= sclk_meta_q;
            sclk_dly_q  <= sclk_sync_q;
            ss_meta_q   <= SS;
            ss_sync_q   <= ss_meta_q;
            mosi_meta_q <= MOSI;
            mosi_sync_q <= mosi_meta_q;
        end
    end

    // Mode configuration tracks the inputs only while deselected
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cpol_q      <= 1'b0;
            cpha_q      <= 1'b0;
            lsb_first_q <= 1'b0;
        end else if (ss_sync_q) begin
            cpol_q      <= CPOL;
            cpha_q      <= CPHA;
            lsb_first_q <= BitOrder;
        end
    end

    // Transmit shadow: filled by handshake, drained at each word start
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shadow_q      <= '0;
            shadow_full_q <= 1'b0;
        end else begin
            if (tx_hs) begin
                shadow_q <= TxData;
            end
            shadow_full_q <= tx_hs | (shadow_full_q & ~word_start);
        end
    end

    // Transfer FSM: word load, bit sampling/shifting, SS-driven abort
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            bit_cnt_q  <= '0;
            fresh_q    <= 1'b0;
            tx_shift_q <= '0;
            rx_shift_q <= '0;
            miso_q     <= 1'b0;
            miso_en_q  <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            underrun_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    miso_en_q <= 1'b0;
                    bit_cnt_q <= '0;
                    fresh_q   <= 1'b0;
                    if (!ss_sync_q) begin
                        state_q <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    if (ss_sync_q) begin
                        state_q   <= ST_IDLE;
                        miso_en_q <= 1'b0;
                    end else begin
                        tx_shift_q <= load_word_d;
                        miso_q     <= lsb_first_q ? load_word_d[0] : load_word_d[WordLen-1];
                        underrun_q <= ~shadow_full_q;
                        miso_en_q  <= 1'b1;
                        fresh_q    <= 1'b1;
                        bit_cnt_q  <= '0;
                        state_q    <= ST_ACTIVE;
                    end
                end
                ST_ACTIVE: begin
                    if (sample_edge) begin
                        rx_shift_q <= rx_shift_d;
                        bit_cnt_q  <= (bit_cnt_q == LAST_BIT) ? '0 : bit_cnt_q + CNT_W'(1);
                    end
                    if (shift_edge) begin
                        fresh_q <= 1'b0;
                        if (reload) begin
                            tx_shift_q <= load_word_d;
                            miso_q     <= lsb_first_q ? load_word_d[0] : load_word_d[WordLen-1];
                            underrun_q <= ~shadow_full_q;
                        end else if (bit_cnt_q != '0) begin
                            tx_shift_q <= tx_shift_d;
                            miso_q     <= lsb_first_q ? tx_shift_d[0] : tx_shift_d[WordLen-1];
                        end
                    end
                    if (ss_sync_q) begin
                        state_q   <= ST_IDLE;
                        bit_cnt_q <= '0;
                        miso_en_q <= 1'b0;
                        fresh_q   <= 1'b0;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Completed word is published one clock after its final sample edge
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_done_q  <= 1'b0;
            rx_valid_q <= 1'b0;
            rx_data_q  <= '0;
        end else begin
            rx_done_q  <= last_sample;
            rx_valid_q <= rx_done_q;
            if (rx_done_q) begin
                rx_data_q <= rx_shift_q;
            end
        end
    end

    assign MISO       = miso_q;
    assign MISOEn     = miso_en_q;
    assign TxReady    = ~shadow_full_q;
    assign RxData     = rx_data_q;
    assign RxValid    = rx_valid_q;
    assign TxUnderrun = underrun_q;
    assign Busy       = ~ss_sync_q;

endmodule

`default_nettype wire

// File: tb/tb_generic_slave_spi.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_generic_slave_spi
// Brief    : Directed bench for generic_slave_spi (8-bit and 16-bit builds)
//            with a behavioural SPI master at 1/10 of the system clock.
// Revision : 1.0 - initial release
// ============================================================================
module tb_generic_slave_spi;

    localparam int HALF = 5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        cpol, cpha, bit_order, sclk, mosi;
    logic        ss8, ss16;
    logic        miso8, misoen8, tx_ready8, rx_valid8, tx_unr8, busy8, tx_valid8;
    logic [7:0]  tx_data8, rx_data8;
    logic        miso16, misoen16, tx_ready16, rx_valid16, tx_unr16, busy16, tx_valid16;
    logic [15:0] tx_data16, rx_data16;

    logic m_cpol, m_cpha, m_lsb;
    int   passed = 0;
    int   total  = 0;
    int   rxv8 = 0, unr8 = 0, rxv16 = 0, unr16 = 0;

    generic_slave_spi #(.WordLen(8), .IdleWord(8'hFF)) dut8 (
        .clk(clk), .reset(reset), .CPOL(cpol), .CPHA(cpha), .BitOrder(bit_order),
        .SCLK(sclk), .SS(ss8), .MOSI(mosi), .MISO(miso8), .MISOEn(misoen8),
        .TxData(tx_data8), .TxValid(tx_valid8), .TxReady(tx_ready8),
        .RxData(rx_data8), .RxValid(rx_valid8), .TxUnderrun(tx_unr8), .Busy(busy8)
    );

    generic_slave_spi #(.WordLen(16)) dut16 (
        .clk(clk), .reset(reset), .CPOL(cpol), .CPHA(cpha), .BitOrder(bit_order),
        .SCLK(sclk), .SS(ss16), .MOSI(mosi), .MISO(miso16), .MISOEn(misoen16),
        .TxData(tx_data16), .TxValid(tx_valid16), .TxReady(tx_ready16),
        .RxData(rx_data16), .RxValid(rx_valid16), .TxUnderrun(tx_unr16), .Busy(busy16)
    );

    // Strobe counters sampled on the falling edge
    always @(negedge clk) begin
        if (rx_valid8)  rxv8  <= rxv8 + 1;
        if (tx_unr8)    unr8  <= unr8 + 1;
        if (rx_valid16) rxv16 <= rxv16 + 1;
        if (tx_unr16)   unr16 <= unr16 + 1;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_mode(input logic c, input logic p, input logic l);
        cpol = c; cpha = p; bit_order = l;
        m_cpol = c; m_cpha = p; m_lsb = l;
        sclk = c;
        tick(4);
    endtask

    task automatic ss_low(input logic w16);
        if (w16) ss16 = 1'b0; else ss8 = 1'b0;
        tick(HALF);
    endtask

    task automatic ss_high(input logic w16);
        tick(HALF);
        if (w16) ss16 = 1'b1; else ss8 = 1'b1;
        tick(2 * HALF);
    endtask

    // Master side of one word; sends nsend of nbits bits. unr_snap records the
    // underrun counter at the last leading edge, before any next-word reload.
    task automatic xfer_word(input logic w16, input int nbits, input int nsend,
                             input logic [15:0] tx, output logic [15:0] rx,
                             output int unr_snap);
        int idx;
        rx = '0;
        unr_snap = 0;
        for (int i = 0; i < nsend; i++) begin
            idx = m_lsb ? i : nbits - 1 - i;
            if (!m_cpha) mosi = tx[idx];
            tick(HALF);
            sclk = ~m_cpol;
            if (!m_cpha) rx[idx] = w16 ? miso16 : miso8;
            else         mosi = tx[idx];
            if (i == nbits - 1) unr_snap = w16 ? unr16 : unr8;
            tick(HALF);
            sclk = m_cpol;
            if (m_cpha) rx[idx] = w16 ? miso16 : miso8;
        end
    endtask

    task automatic test_reset();
        total++; if (miso8 !== 1'b0)      $display("FAIL reset_miso: got %b expected 0", miso8);       else passed++;
        total++; if (misoen8 !== 1'b0)    $display("FAIL reset_misoen: got %b expected 0", misoen8);   else passed++;
        total++; if (tx_ready8 !== 1'b1)  $display("FAIL reset_txready: got %b expected 1", tx_ready8); else passed++;
        total++; if (rx_data8 !== 8'h00)  $display("FAIL reset_rxdata: got %h expected 00", rx_data8); else passed++;
        total++; if (rx_valid8 !== 1'b0)  $display("FAIL reset_rxvalid: got %b expected 0", rx_valid8); else passed++;
        total++; if (tx_unr8 !== 1'b0)    $display("FAIL reset_underrun: got %b expected 0", tx_unr8);  else passed++;
        total++; if (busy8 !== 1'b0)      $display("FAIL reset_busy: got %b expected 0", busy8);       else passed++;
    endtask

    task automatic test_mode0();
        logic [15:0] rx; int snap, u0, v0;
        set_mode(1'b0, 1'b0, 1'b0);
        tx_data8 = 8'hA5; tx_valid8 = 1'b1; tick(1); tx_valid8 = 1'b0;
        total++; if (tx_ready8 !== 1'b0) $display("FAIL mode0_txready_drop: got %b expected 0", tx_ready8); else passed++;
        u0 = unr8; v0 = rxv8;
        ss_low(1'b0);
        total++; if (misoen8 !== 1'b1) $display("FAIL mode0_misoen: got %b expected 1", misoen8); else passed++;
        total++; if (busy8 !== 1'b1)   $display("FAIL mode0_busy: got %b expected 1", busy8);     else passed++;
        total++; if (tx_ready8 !== 1'b1) $display("FAIL mode0_txready_rise: got %b expected 1", tx_ready8); else passed++;
        xfer_word(1'b0, 8, 8, 16'h003C, rx, snap);
        ss_high(1'b0);
        total++; if (rx[7:0] !== 8'hA5)   $display("FAIL mode0_master_rx: got %h expected a5", rx[7:0]);   else passed++;
        total++; if (rx_data8 !== 8'h3C)  $display("FAIL mode0_rxdata: got %h expected 3c", rx_data8);     else passed++;
        total++; if (rxv8 - v0 !== 1)     $display("FAIL mode0_rxvalid_count: got %0d expected 1", rxv8 - v0); else passed++;
        total++; if (snap - u0 !== 0)     $display("FAIL mode0_underrun: got %0d expected 0", snap - u0);  else passed++;
        total++; if (misoen8 !== 1'b0)    $display("FAIL mode0_misoen_idle: got %b expected 0", misoen8);  else passed++;
    endtask

    task automatic test_back_to_back();
        logic [15:0] rx1, rx2; int snap1, snap2, u0, v0;
        set_mode(1'b1, 1'b1, 1'b1);
        tx_data8 = 8'h12; tx_valid8 = 1'b1; tick(1); tx_valid8 = 1'b0;
        u0 = unr8; v0 = rxv8;
        ss_low(1'b0);
        fork
            xfer_word(1'b0, 8, 8, 16'h0081, rx1, snap1);
            begin
                tick(20);
                tx_data8 = 8'h34; tx_valid8 = 1'b1; tick(1); tx_valid8 = 1'b0;
            end
        join
        tick(HALF);
        total++; if (rx_data8 !== 8'h81) $display("FAIL b2b_rxdata1: got %h expected 81", rx_data8); else passed++;
        xfer_word(1'b0, 8, 8, 16'h007E, rx2, snap2);
        ss_high(1'b0);
        total++; if (rx1[7:0] !== 8'h12) $display("FAIL b2b_master_rx1: got %h expected 12", rx1[7:0]); else passed++;
        total++; if (rx2[7:0] !== 8'h34) $display("FAIL b2b_master_rx2: got %h expected 34", rx2[7:0]); else passed++;
        total++; if (rx_data8 !== 8'h7E) $display("FAIL b2b_rxdata2: got %h expected 7e", rx_data8);     else passed++;
        total++; if (rxv8 - v0 !== 2)    $display("FAIL b2b_rxvalid_count: got %0d expected 2", rxv8 - v0); else passed++;
        total++; if (snap2 - u0 !== 0)   $display("FAIL b2b_underrun: got %0d expected 0", snap2 - u0);  else passed++;
    endtask

    task automatic test_underrun();
        logic [15:0] rx; int snap, u0, v0;
        logic [7:0] w;
        for (int m = 0; m < 2; m++) begin
            set_mode(m == 1, m == 0, 1'b0);
            w = (m == 0) ? 8'h5A : 8'hA6;
            u0 = unr8; v0 = rxv8;
            ss_low(1'b0);
            xfer_word(1'b0, 8, 8, {8'h00, w}, rx, snap);
            ss_high(1'b0);
            total++; if (rx[7:0] !== 8'hFF) $display("FAIL underrun_master_rx m%0d: got %h expected ff", m, rx[7:0]); else passed++;
            total++; if (snap - u0 !== 1)   $display("FAIL underrun_pulses m%0d: got %0d expected 1", m, snap - u0); else passed++;
            total++; if (rx_data8 !== w)    $display("FAIL underrun_rxdata m%0d: got %h expected %h", m, rx_data8, w); else passed++;
            total++; if (rxv8 - v0 !== 1)   $display("FAIL underrun_rxvalid m%0d: got %0d expected 1", m, rxv8 - v0); else passed++;
        end
    endtask

    task automatic test_abort();
        logic [15:0] rx; int snap, v0;
        set_mode(1'b0, 1'b0, 1'b0);
        v0 = rxv8;
        ss_low(1'b0);
        xfer_word(1'b0, 8, 5, 16'h00C3, rx, snap);
        ss8 = 1'b1;
        tick(3);
        total++; if (misoen8 !== 1'b0)   $display("FAIL abort_misoen: got %b expected 0", misoen8);   else passed++;
        tick(10);
        total++; if (rxv8 - v0 !== 0)    $display("FAIL abort_rxvalid: got %0d expected 0", rxv8 - v0); else passed++;
        total++; if (rx_data8 !== 8'hA6) $display("FAIL abort_rxdata_held: got %h expected a6", rx_data8); else passed++;
        total++; if (busy8 !== 1'b0)     $display("FAIL abort_busy: got %b expected 0", busy8);       else passed++;
        ss_low(1'b0);
        xfer_word(1'b0, 8, 8, 16'h0055, rx, snap);
        ss_high(1'b0);
        total++; if (rx_data8 !== 8'h55) $display("FAIL abort_next_rxdata: got %h expected 55", rx_data8); else passed++;
        total++; if (rxv8 - v0 !== 1)    $display("FAIL abort_next_rxvalid: got %0d expected 1", rxv8 - v0); else passed++;
    endtask

    task automatic test_reset_mid();
        logic [15:0] rx; int snap, v0;
        set_mode(1'b0, 1'b0, 1'b0);
        tx_data8 = 8'h77; tx_valid8 = 1'b1; tick(1); tx_valid8 = 1'b0;
        ss_low(1'b0);
        tx_data8 = 8'h66; tx_valid8 = 1'b1; tick(1); tx_valid8 = 1'b0;
        xfer_word(1'b0, 8, 4, 16'h0099, rx, snap);
        reset = 1'b0;
        #1;
        total++; if (misoen8 !== 1'b0)   $display("FAIL rstmid_misoen: got %b expected 0", misoen8);    else passed++;
        total++; if (miso8 !== 1'b0)     $display("FAIL rstmid_miso: got %b expected 0", miso8);        else passed++;
        total++; if (tx_ready8 !== 1'b1) $display("FAIL rstmid_txready: got %b expected 1", tx_ready8); else passed++;
        total++; if (rx_data8 !== 8'h00) $display("FAIL rstmid_rxdata: got %h expected 00", rx_data8);  else passed++;
        total++; if (busy8 !== 1'b0)     $display("FAIL rstmid_busy: got %b expected 0", busy8);        else passed++;
        ss8 = 1'b1;
        tick(2);
        reset = 1'b1;
        tick(4);
        v0 = rxv8;
        tx_data8 = 8'h3A; tx_valid8 = 1'b1; tick(1); tx_valid8 = 1'b0;
        ss_low(1'b0);
        xfer_word(1'b0, 8, 8, 16'h0099, rx, snap);
        ss_high(1'b0);
        total++; if (rx_data8 !== 8'h99) $display("FAIL rstmid_after_rxdata: got %h expected 99", rx_data8); else passed++;
        total++; if (rx[7:0] !== 8'h3A)  $display("FAIL rstmid_after_master_rx: got %h expected 3a", rx[7:0]); else passed++;
        total++; if (rxv8 - v0 !== 1)    $display("FAIL rstmid_after_rxvalid: got %0d expected 1", rxv8 - v0); else passed++;
    endtask

    task automatic test_word16();
        logic [15:0] rx; int snap, v0;
        set_mode(1'b0, 1'b0, 1'b0);
        tx_data16 = 16'h1234; tx_valid16 = 1'b1; tick(1); tx_valid16 = 1'b0;
        v0 = rxv16;
        ss_low(1'b1);
        fork
            xfer_word(1'b1, 16, 16, 16'hBEEF, rx, snap);
            begin
                tick(40);
                cpol = 1'b1; cpha = 1'b1; bit_order = 1'b1;
            end
        join
        cpol = 1'b0; cpha = 1'b0; bit_order = 1'b0;
        ss_high(1'b1);
        total++; if (rx !== 16'h1234)       $display("FAIL w16_master_rx: got %h expected 1234", rx);     else passed++;
        total++; if (rx_data16 !== 16'hBEEF) $display("FAIL w16_rxdata: got %h expected beef", rx_data16); else passed++;
        total++; if (rxv16 - v0 !== 1)      $display("FAIL w16_rxvalid: got %0d expected 1", rxv16 - v0); else passed++;
    endtask

    initial begin
        reset = 1'b0;
        cpol = 1'b0; cpha = 1'b0; bit_order = 1'b0;
        m_cpol = 1'b0; m_cpha = 1'b0; m_lsb = 1'b0;
        sclk = 1'b0; mosi = 1'b0; ss8 = 1'b1; ss16 = 1'b1;
        tx_data8 = '0; tx_valid8 = 1'b0; tx_data16 = '0; tx_valid16 = 1'b0;
        tick(3);
        test_reset();
        reset = 1'b1;
        tick(3);
        test_mode0();
        test_back_to_back();
        test_underrun();
        test_abort();
        test_reset_mid();
        test_word16();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/generic_slave_spi.md
Name: generic_slave_spi

Overview:
SPI slave/responder that is the far end of our SPI master. It runs entirely in the system clock domain and oversamples SCLK, SS and MOSI through 2-FF synchronizers. It shifts WordLen-bit words full-duplex in all four CPOL/CPHA modes with selectable bit order. It exposes a valid/ready transmit interface and a single-cycle receive strobe to local logic.

Parameters:
WordLen, 8, bits per SPI word (2..32)
IdleWord, 0 (WordLen bits), word shifted out on MISO when no transmit data is queued

Ports:
clk  input  1  system clock; must be at least 8x the SCLK frequency
reset  input  1  reset; one clock; reset is asynchronous and active-low
CPOL  input  1  clock idle level; sampled only while SS is deasserted
CPHA  input  1  clock phase; sampled only while SS is deasserted
BitOrder  input  1  0 = MSB first, 1 = LSB first; sampled only while SS is deasserted
SCLK  input  1  SPI clock from master (asynchronous)
SS  input  1  slave select, active-low (asynchronous)
MOSI  input  1  master data in (asynchronous)
MISO  output  1  slave data out
MISOEn  output  1  MISO drive enable; pad tristates MISO when low
TxData  input  WordLen  next word to transmit
TxValid  input  1  TxData valid
TxReady  output  1  shadow register empty, can accept TxData
RxData  output  WordLen  last complete received word; held until the next word completes
RxValid  output  1  one-clk strobe, RxData updated
TxUnderrun  output  1  one-clk strobe, word started with no queued TxData
Busy  output  1  synchronized SS is low (transaction active)

Behaviour:
- Reset (reset=0), asynchronous: all flops clear. Outputs: MISO=0, MISOEn=0, TxReady=1, RxData=0, RxValid=0, TxUnderrun=0, Busy=0. The FSM goes to IDLE and the shadow register is marked empty. Reset asserted mid-transfer aborts the word with no strobes.
- Sync: SCLK, SS and MOSI pass through 2-FF synchronizers. SCLK edges are detected from the synced value and its 1-clk delayed copy.
- The leading edge is the transition away from CPOLR; the trailing edge is the return to CPOLR.
- CPHA=0: sample on leading, shift on trailing. CPHA=1: shift on leading, sample on trailing.
- Config regs: CPOLR, CPHAR and BitOrderR load every clk while synced SS is high, and freeze while it is low.
- Transmit handshake:
  - TxValid&TxReady loads the shadow register; TxReady drops the next clk.
  - The shadow drains into the shift register at word start, and TxReady rises the next clk.
  - Shadow contents survive an aborted word.
- FSM IDLE: MISOEn=0, bit counter=0. When synced SS falls, go to LOAD.
- FSM LOAD (1 clk):
  - Shift register takes the shadow if full; otherwise it takes IdleWord and pulses TxUnderrun.
  - MISOEn=1. MISO presents the first bit: MSB if BitOrderR=0, else LSB.
  - Go to ACTIVE.
- FSM ACTIVE:
  - Each sample edge captures synced MOSI into the receive shift register (shifting in at the LSB for MSB-first, at the MSB for LSB-first) and increments the bit counter.
  - Each shift edge advances MISO to the next bit. For CPHA=1 the first leading edge does not shift, because bit 0 is already presented.
  - When the counter reaches WordLen at a sample edge: RxData takes the completed word on the next clk, RxValid pulses 1 clk, and the counter wraps to 0.
  - If SS is still low, the next word loads exactly as in LOAD at the following shift-edge boundary (CPHA=0: the trailing edge after the last sample; CPHA=1: the next leading edge), with the same underrun rule.
- Latency: RxValid asserts 1 clk after the clk in which the final sample edge is detected, i.e. 4 clk after the physical SCLK edge including synchronization.
- SS rising (synced) in any state:
  - Go to IDLE in the same clk, clear the counter, MISOEn=0.
  - A partial word is discarded with no RxValid.
  - SS rising in the same clk as the final sample edge: the word completes and RxValid still fires.
- A TxValid&TxReady handshake in the same clk as a word-start drain: the drain uses the old shadow state (empty gives underrun), and the new word lands in the shadow.
- Config changes while SS is low are ignored until SS is high again.

Test Plan:
- Mode 0, MSB first, TxData=0xA5 queued, master sends 0x3C at 1/10 clk rate → master receives 0xA5, RxData=0x3C, one RxValid, no TxUnderrun.
- Mode 3, LSB first, two back-to-back words with SS held low: master sends 0x81 then 0x7E, slave queues 0x12 then 0x34 via handshake during word 1 → RxValid twice (0x81, 0x7E), master receives 0x12, 0x34.
- Modes 1 and 2, nothing queued, IdleWord=0xFF → TxUnderrun pulses once per word, master receives 0xFF.
- SS deasserted after 5 bits of 0xC3 → no RxValid, RxData unchanged, MISOEn=0 within 3 clk; next full transfer of 0x55 yields RxData=0x55.
- reset pulled low mid-word → all outputs at reset values immediately; after release, a mode 0 transfer of 0x99 completes correctly.
- WordLen=16, mode 0, master sends 0xBEEF, slave sends 0x1234 → RxData=0xBEEF, master receives 0x1234; CPOL toggled mid-transfer has no effect.
